// File: rtl/host_uart_pkg.sv
// Shared types and constants for the host UART frame assembler.
// Checksum support is selected elsewhere by HOST_UART_ASM_CHECKSUM_EN.
package host_uart_pkg;

    localparam int FRAME_W             = 1024;
    localparam int DEFAULT_MAX_PAYLOAD = 128;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PAYLOAD  = 2'd1,
        ST_CSUM     = 2'd2,
        ST_WAIT_DEC = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_BAD_LEN  = 3'd1,
        ERR_TIMEOUT  = 3'd2,
        ERR_OVERRUN  = 3'd3,
        ERR_CHECKSUM = 3'd4
    } err_e;

endpackage

// File: rtl/host_uart_gap_timer.sv
// Counts idle cycles between received bytes; saturates at TIMEOUT_CYCLES and
// flags expiry while enabled.
module host_uart_gap_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!enable || clear) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/host_uart_frame_assembler.sv
// Assembles length-prefixed UART bytes into a 1024-bit command frame and
// launches the decoder. Optional trailing checksum: HOST_UART_ASM_CHECKSUM_EN.
module host_uart_frame_assembler
    import host_uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MAX_PAYLOAD    = DEFAULT_MAX_PAYLOAD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               dec_done,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_start,
    output logic [7:0]         frame_len,
    output logic               busy,
    output logic               error,
    output logic [2:0]         err_code
);

    state_e     state;
    state_e     state_next;
    logic [6:0] byte_idx;
    logic       last_byte;
    logic       gap_expired;
    logic       accept_len;
    logic       write_byte;
    logic       start_set;
    logic       err_set;
    err_e       err_val;
`ifdef HOST_UART_ASM_CHECKSUM_EN
    logic [7:0] csum;
`endif

    host_uart_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .enable ((state == ST_PAYLOAD) || (state == ST_CSUM)),
        .clear  (rx_valid),
        .expired(gap_expired)
    );

    assign last_byte = ({1'b0, byte_idx} == (frame_len - 8'd1));
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A received byte always takes priority over an expiring gap timer.
    always_comb begin
        state_next = state;
        accept_len = 1'b0;
        write_byte = 1'b0;
        start_set  = 1'b0;
        err_set    = 1'b0;
        err_val    = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || int'(rx_data) > MAX_PAYLOAD) begin
                        err_set = 1'b1;
                        err_val = ERR_BAD_LEN;
                    end else begin
                        accept_len = 1'b1;
                        state_next = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    write_byte = 1'b1;
                    if (last_byte) begin
`ifdef HOST_UART_ASM_CHECKSUM_EN
                        state_next = ST_CSUM;
`else
                        state_next = ST_WAIT_DEC;
`endif
                    end
                end else if (gap_expired) begin
                    err_set    = 1'b1;
                    err_val    = ERR_TIMEOUT;
                    state_next = ST_IDLE;
                end
            end
            ST_CSUM: begin
`ifdef HOST_UART_ASM_CHECKSUM_EN
                if (rx_valid) begin
                    if (rx_data == csum) begin
                        state_next = ST_WAIT_DEC;
                    end else begin
                        err_set    = 1'b1;
                        err_val    = ERR_CHECKSUM;
                        state_next = ST_IDLE;
                    end
                end else if (gap_expired) begin
                    err_set    = 1'b1;
                    err_val    = ERR_TIMEOUT;
                    state_next = ST_IDLE;
                end
`else
                state_next = ST_IDLE;
`endif
            end
            ST_WAIT_DEC: begin
                if (rx_valid) begin
                    err_set = 1'b1;
                    err_val = ERR_OVERRUN;
                end
                if (dec_done) begin
                    start_set  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // frame_data/frame_len only change on an accepted length byte or a payload
    // write, so they stay stable for the decoder throughout WAIT_DEC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_data  <= '0;
            frame_len   <= 8'd0;
            byte_idx    <= 7'd0;
            frame_start <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
`ifdef HOST_UART_ASM_CHECKSUM_EN
            csum        <= 8'd0;
`endif
        end else begin
            frame_start <= start_set;
            error       <= err_set;
            if (err_set) begin
                err_code <= err_val;
            end
            if (accept_len) begin
                frame_data <= '0;
                frame_len  <= rx_data;
                byte_idx   <= 7'd0;
`ifdef HOST_UART_ASM_CHECKSUM_EN
                csum       <= rx_data;
`endif
            end
            if (write_byte) begin
                frame_data[{byte_idx, 3'b000} +: 8] <= rx_data;
                byte_idx <= byte_idx + 7'd1;
`ifdef HOST_UART_ASM_CHECKSUM_EN
                csum     <= csum ^ rx_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_host_uart_frame_assembler.sv
// Scoreboard bench for host_uart_frame_assembler: stimulus pushes expected
// launches/errors, a negedge monitor pops and compares them.
module tb_host_uart_frame_assembler;

    localparam int TMO   = 20;
    localparam int FW    = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          dec_done;
    logic [FW-1:0] frame_data;
    logic          frame_start;
    logic [7:0]    frame_len;
    logic          busy;
    logic          error;
    logic [2:0]    err_code;

    typedef struct {
        bit            is_start;
        logic [2:0]    code;
        logic [7:0]    len;
        logic [FW-1:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] payload [0:127];
    int         n_checks = 0;
    int         n_errors = 0;

    host_uart_frame_assembler #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .dec_done   (dec_done),
        .frame_data (frame_data),
        .frame_start(frame_start),
        .frame_len  (frame_len),
        .busy       (busy),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_frame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        int bad;
        bad = -1;
        for (int w = 15; w >= 0; w--) begin
            if (act[w*64 +: 64] !== exp[w*64 +: 64]) bad = w;
        end
        n_checks++;
        if (bad >= 0) begin
            n_errors++;
            $display("[TB] FAIL %s word %0d: got %h, expected %h", name, bad,
                     act[bad*64 +: 64], exp[bad*64 +: 64]);
        end
    endtask

    function automatic logic [FW-1:0] model_frame(input int len);
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < len; i++) f[i*8 +: 8] = payload[i];
        return f;
    endfunction

    task automatic push_start(input int len);
        exp_t e;
        e.is_start = 1'b1;
        e.code     = 3'd0;
        e.len      = 8'(len);
        e.data     = model_frame(len);
        exp_q.push_back(e);
    endtask

    task automatic push_error(input logic [2:0] code);
        exp_t e;
        e.is_start = 1'b0;
        e.code     = code;
        e.len      = 8'd0;
        e.data     = '0;
        exp_q.push_back(e);
    endtask

    // Strobe one byte, then idle for gap cycles; returns 1 time unit after an edge.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Length byte, payload, optional checksum; the final byte has no trailing gap.
    task automatic send_frame(input int len, input int max_gap);
        logic [7:0] x;
        x = 8'(len);
        applyStimulus(8'(len), $urandom_range(max_gap, 0));
        for (int i = 0; i < len; i++) begin
            x = x ^ payload[i];
`ifdef HOST_UART_ASM_CHECKSUM_EN
            applyStimulus(payload[i], $urandom_range(max_gap, 0));
`else
            applyStimulus(payload[i], (i == len - 1) ? 0 : $urandom_range(max_gap, 0));
`endif
        end
`ifdef HOST_UART_ASM_CHECKSUM_EN
        applyStimulus(x, 0);
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n && (frame_start || error)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL unexpected_output: got start=%0b error=%0b code=%0d, expected no output",
                         frame_start, error, err_code);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_start) begin
                    checkOutput("event_is_start", 64'(frame_start), 64'd1);
                    checkOutput("start_frame_len", 64'(frame_len), 64'(mon_e.len));
                    check_frame("start_frame_data", frame_data, mon_e.data);
                end else begin
                    checkOutput("event_is_error", 64'(error), 64'd1);
                    checkOutput("err_code", 64'(err_code), 64'(mon_e.code));
                end
            end
        end
    end

    initial begin
        int len;
        bit dd;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        dec_done = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        checkOutput("reset_frame_start", 64'(frame_start), 64'd0);
        checkOutput("reset_frame_len", 64'(frame_len), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_error", 64'(error), 64'd0);
        checkOutput("reset_err_code", 64'(err_code), 64'd0);
        check_frame("reset_frame_data", frame_data, '0);

        // Basic frame with exact handoff latency, then back-to-back length byte.
        payload[0] = 8'h01; payload[1] = 8'hFF; payload[2] = 8'hFF;
        push_start(3);
        send_frame(3, 1);
        checkOutput("wait_dec_busy", 64'(busy), 64'd1);
        idle(1);
        checkOutput("start_latency", 64'(frame_start), 64'd1);
        checkOutput("idle_after_start", 64'(busy), 64'd0);
        checkOutput("frame_low24", 64'(frame_data[23:0]), 64'hFFFF01);
        checkOutput("frame_len_3", 64'(frame_len), 64'd3);
        payload[0] = 8'hAA;
        push_start(1);
        send_frame(1, 0);
        checkOutput("back_to_back_busy", 64'(busy), 64'd1);
        idle(3);

        // Bad lengths.
        push_error(3'd1);
        applyStimulus(8'h00, 1);
        checkOutput("bad_len0_busy", 64'(busy), 64'd0);
        push_error(3'd1);
        applyStimulus(8'h81, 1);
        checkOutput("bad_len81_busy", 64'(busy), 64'd0);
        idle(3);

        // Timeout mid-payload, then a good frame.
        push_error(3'd2);
        applyStimulus(8'h04, 0);
        applyStimulus(8'h11, 1);
        applyStimulus(8'h22, 0);
        idle(TMO + 5);
        checkOutput("timeout_idle", 64'(busy), 64'd0);
        checkOutput("timeout_code_held", 64'(err_code), 64'd2);
        payload[0] = 8'h3C; payload[1] = 8'h5D;
        push_start(2);
        send_frame(2, 2);
        idle(3);

        // Overrun while decoder busy; frame held, launched on dec_done.
        dec_done = 1'b0;
        payload[0] = 8'h5A; payload[1] = 8'hC3;
        push_error(3'd3);
        push_start(2);
        send_frame(2, 1);
        applyStimulus(8'h77, 2);
        checkOutput("overrun_busy", 64'(busy), 64'd1);
        checkOutput("overrun_len_held", 64'(frame_len), 64'd2);
        check_frame("overrun_data_held", frame_data, model_frame(2));
        dec_done = 1'b1;
        idle(1);
        checkOutput("start_after_done", 64'(frame_start), 64'd1);
        idle(3);

`ifdef HOST_UART_ASM_CHECKSUM_EN
        payload[0] = 8'h03; payload[1] = 8'h10;
        push_start(2);
        send_frame(2, 1);
        idle(4);
        push_error(3'd4);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h03, 0);
        applyStimulus(8'h10, 0);
        applyStimulus(8'h12, 3);
        checkOutput("csum_bad_idle", 64'(busy), 64'd0);
`endif

        // Reset in the middle of a frame.
        applyStimulus(8'h05, 0);
        applyStimulus(8'hA1, 0);
        applyStimulus(8'hA2, 1);
        applyStimulus(8'hA3, 0);
        rst_n = 1'b0;
        #2;
        checkOutput("midreset_frame_start", 64'(frame_start), 64'd0);
        checkOutput("midreset_frame_len", 64'(frame_len), 64'd0);
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_error", 64'(error), 64'd0);
        checkOutput("midreset_err_code", 64'(err_code), 64'd0);
        check_frame("midreset_frame_data", frame_data, '0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 5; i++) payload[i] = 8'(8'hB0 + i);
        push_start(5);
        send_frame(5, 2);
        idle(3);

        // Randomized frames against the reference model.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(7, 0) == 0) begin
                push_error(3'd1);
                applyStimulus(($urandom_range(1, 0) == 1) ? 8'h00 : 8'($urandom_range(255, 129)), 1);
            end else begin
                len = ($urandom_range(1, 0) == 1) ? $urandom_range(8, 1) : $urandom_range(128, 1);
                for (int i = 0; i < len; i++) payload[i] = 8'($urandom);
                dd = 1'($urandom_range(1, 0));
                dec_done = dd;
                push_start(len);
                send_frame(len, 3);
                if (!dd) begin
                    idle($urandom_range(6, 1));
                    dec_done = 1'b1;
                end
                idle($urandom_range(3, 1));
            end
        end

        idle(10);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
